bcd_entry: RTL

Keypad-side operand entry stage of the calculator, directly upstream of the BCD-to-binary converter. It collects decimal digit key strobes into a packed BCD operand and supports clear and backspace. On ENTER it launches a conversion with a single-cycle `init` pulse, then waits for the converter's `done` before flagging the operand as converted. The operand is held stable for the whole conversion.

---
 rtl/bcd_entry_pkg.sv | 22 ++
 rtl/bcd_entry_if.sv | 28 ++
 rtl/bcd_digit_buf.sv | 40 ++++
 rtl/bcd_entry.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/bcd_entry_pkg.sv
// Shared key codes, FSM state encoding and helpers for the keypad operand entry stage.
package bcd_entry_pkg;

    localparam int unsigned KEY_W = 4;

    localparam logic [KEY_W-1:0] KEY_CLR = 4'hA;
    localparam logic [KEY_W-1:0] KEY_BSP = 4'hB;
    localparam logic [KEY_W-1:0] KEY_ENT = 4'hC;

    typedef enum logic [2:0] {
        EMPTY,
        ENTRY,
        LAUNCH,
        WAIT,
        HOLD
    } state_e;

    function automatic logic is_digit(input logic [KEY_W-1:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_entry_if.sv
// Keypad/converter-side bus of bcd_entry; master drives keys and converter done, slave is the entry stage.
interface bcd_entry_if #(
    parameter int unsigned NDIGITS = 4
);
    localparam int unsigned BCD_W = 4 * NDIGITS;
    localparam int unsigned CNT_W = $clog2(NDIGITS + 1);

    logic             key_valid;
    logic [3:0]       key_code;
    logic             conv_done;
    logic [BCD_W-1:0] bcd_out;
    logic [CNT_W-1:0] digit_cnt;
    logic             init;
    logic             busy;
    logic             full;
    logic             ready;
    logic             key_err;

    modport master (
        output key_valid, key_code, conv_done,
        input  bcd_out, digit_cnt, init, busy, full, ready, key_err
    );

    modport slave (
        input  key_valid, key_code, conv_done,
        output bcd_out, digit_cnt, init, busy, full, ready, key_err
    );
endinterface

// File: rtl/bcd_digit_buf.sv
// Packed BCD operand buffer: load first digit, shift digits in at the units end,
// drop the units digit on backspace, clear; tracks significant digit count and full.
module bcd_digit_buf #(
    parameter  int unsigned NDIGITS = 4,
    localparam int unsigned BCD_W   = 4 * NDIGITS,
    localparam int unsigned CNT_W   = $clog2(NDIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_in,
    input  logic             shift_out,
    input  logic             clear,
    input  logic [3:0]       digit,
    output logic [BCD_W-1:0] bcd,
    output logic [CNT_W-1:0] cnt,
    output logic             full
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bcd  <= '0;
            cnt  <= '0;
            full <= 1'b0;
        end else if (load) begin
            bcd  <= BCD_W'(digit);
            cnt  <= CNT_W'(1);
            full <= (NDIGITS == 1);
        end else if (shift_in && !full) begin
            bcd  <= BCD_W'({bcd, digit});
            cnt  <= cnt + CNT_W'(1);
            full <= ((cnt + CNT_W'(1)) == CNT_W'(NDIGITS));
        end else if (shift_out && (cnt != '0)) begin
            bcd  <= bcd >> 4;
            cnt  <= cnt - CNT_W'(1);
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/bcd_entry.sv
// Keypad operand entry FSM feeding the BCD-to-binary converter; launches with init, waits for done.
// Optional backspace editing in ENTRY is enabled by defining BCD_ENTRY_BACKSPACE_EN.
module bcd_entry
    import bcd_entry_pkg::*;
#(
    parameter int unsigned NDIGITS = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input logic        clk,
    input logic        rst,
    bcd_entry_if.slave bus
);

    localparam int unsigned BCD_W = 4 * NDIGITS;
    localparam int unsigned CNT_W = $clog2(NDIGITS + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             conv_done_q;
    logic             key_err_q, key_err_d;
    logic             busy_q, ready_q;
    logic             init_c;

    logic             buf_load, buf_shift_in, buf_shift_out, buf_clear;
    logic [BCD_W-1:0] bcd;
    logic [CNT_W-1:0] cnt;
    logic             full;

    logic             key_dig, key_nz, key_clr, key_ent, busy_rej;

    assign key_dig = bus.key_valid && is_digit(bus.key_code);
    assign key_nz  = key_dig && (bus.key_code != 4'd0);
    assign key_clr = bus.key_valid && (bus.key_code == KEY_CLR);
    assign key_ent = bus.key_valid && (bus.key_code == KEY_ENT);

    // Keys that draw key_err while a conversion is in flight; 0xD-0xF stay silent.
`ifdef BCD_ENTRY_BACKSPACE_EN
    assign busy_rej = bus.key_valid && (bus.key_code <= KEY_ENT);
`else
    assign busy_rej = bus.key_valid && (bus.key_code <= KEY_ENT) && (bus.key_code != KEY_BSP);
`endif

    bcd_digit_buf #(.NDIGITS(NDIGITS)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (buf_load),
        .shift_in (buf_shift_in),
        .shift_out(buf_shift_out),
        .clear    (buf_clear),
        .digit    (bus.key_code),
        .bcd      (bcd),
        .cnt      (cnt),
        .full     (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            tmo_q       <= '0;
            conv_done_q <= 1'b0;
            key_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            conv_done_q <= bus.conv_done;
            key_err_q   <= key_err_d;
            busy_q      <= (state_d == LAUNCH) || (state_d == WAIT);
            ready_q     <= (state_d == HOLD);
        end
    end

    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        key_err_d     = 1'b0;
        init_c        = 1'b0;
        buf_load      = 1'b0;
        buf_shift_in  = 1'b0;
        buf_shift_out = 1'b0;
        buf_clear     = 1'b0;

        case (state_q)
            EMPTY: begin
                if (key_nz) begin
                    buf_load = 1'b1;
                    state_d  = ENTRY;
                end else if (key_ent) begin
                    key_err_d = 1'b1;
                end
            end
            ENTRY: begin
                if (key_dig) begin
                    if (full) key_err_d    = 1'b1;
                    else      buf_shift_in = 1'b1;
                end else if (key_clr) begin
                    buf_clear = 1'b1;
                    state_d   = EMPTY;
                end else if (key_ent) begin
                    state_d = LAUNCH;
                end
`ifdef BCD_ENTRY_BACKSPACE_EN
                else if (bus.key_valid && (bus.key_code == KEY_BSP)) begin
                    buf_shift_out = 1'b1;
                    if (cnt == CNT_W'(1)) state_d = EMPTY;
                end
`endif
            end
            // Converter still asserting done from a previous run: hold off init.
            LAUNCH: begin
                key_err_d = busy_rej;
                if (!bus.conv_done) begin
                    init_c  = 1'b1;
                    tmo_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                key_err_d = busy_rej;
                if (bus.conv_done && !conv_done_q) begin
                    state_d = HOLD;
                end else if ((tmo_q + TMO_W'(1)) == TMO_W'(TIMEOUT)) begin
                    key_err_d = 1'b1;
                    buf_clear = 1'b1;
                    tmo_d     = '0;
                    state_d   = EMPTY;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            HOLD: begin
                if (key_nz) begin
                    buf_load = 1'b1;
                    state_d  = ENTRY;
                end else if (key_dig || key_clr) begin
                    buf_clear = 1'b1;
                    state_d   = EMPTY;
                end else if (key_ent) begin
                    state_d = LAUNCH;
                end
            end
            default: begin
                buf_clear = 1'b1;
                state_d   = EMPTY;
            end
        endcase
    end

    assign bus.bcd_out   = bcd;
    assign bus.digit_cnt = cnt;
    assign bus.full      = full;
    assign bus.init      = init_c;
    assign bus.busy      = busy_q;
    assign bus.ready     = ready_q;
    assign bus.key_err   = key_err_q;

endmodule
